// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle sequencer between the control FSM and the
// unified instruction/data memory. A request is latched on acceptance, the
// memory interface is held stable for LATENCY cycles, and read data is then
// committed to IR or MDR, followed by a one-cycle done pulse.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to flag word-misaligned
// accesses. A flagged access still runs through BUSY and DONE, but it never
// writes memory and never captures into IR or MDR. Without the macro,
// misaligned is tied low and every access commits normally.
module mem_access_unit #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       ir,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Request attributes that must stay fixed for the whole access.
  typedef struct packed {
    logic wr;       // store (a read+write request is treated as a store)
    logic iord;     // 1 = data access, 0 = instruction fetch
    logic irwrite;  // fetch may load IR
    logic bad;      // misaligned, so commit is suppressed
  } req_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  req_t              req;
  logic              req_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_bad;
  logic              last_cyc;

  assign req_any  = mem_read | mem_write;
  assign sel_addr = IorD ? alu_out : pc;
  assign last_cyc = (state == S_BUSY) && (cnt == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
  assign sel_bad = (sel_addr[1:0] != 2'b00);
`else
  assign sel_bad = 1'b0;
`endif

  // Next-state and interface strobes; strobes decode directly from state, so
  // a reset edge drops mem_we on that same edge.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) state_nx = S_BUSY;
      end
      S_BUSY: begin
        busy   = 1'b1;
        mem_re = ~req.wr;
        mem_we = req.wr & ~req.bad & (cnt == 4'd0);
        if (cnt == 4'd0) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register, request latch, latency counter and read-data commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && req_any) begin
        mem_addr    <= sel_addr;
        mem_wdata   <= write_data;
        req.wr      <= mem_write;
        req.iord    <= IorD;
        req.irwrite <= IRWrite;
        req.bad     <= sel_bad;
        cnt         <= 4'(LATENCY - 1);
      end else if (state == S_BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (last_cyc && !req.wr && !req.bad) begin
        if (req.iord)         mdr <= mem_rdata;
        else if (req.irwrite) ir  <= 32'(mem_rdata);
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Sticky error flag, set when a misaligned request is accepted.
  always_ff @(posedge clk) begin
    if (reset)                                    misaligned <= 1'b0;
    else if (state == S_IDLE && req_any && sel_bad) misaligned <= 1'b1;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table-driven single requests with
// a scoreboard of expected IR/MDR, plus hand sequences for read+write
// re-acceptance, reset mid-store and the LATENCY=1 boundary.
module tb_mem_access_unit;
  localparam int LAT = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, write_data = '0, mem_rdata = '0;
  logic [31:0] mem_addr, mem_wdata, ir, mdr;
  logic        mem_re, mem_we, busy, done, misaligned;
  logic [31:0] u1_addr, u1_wdata, u1_ir, u1_mdr;
  logic        u1_re, u1_we, u1_busy, u1_done, u1_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
    .write_data(write_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .ir(ir),
    .mdr(mdr), .busy(busy), .done(done), .misaligned(misaligned));

  mem_access_unit #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) u1 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .IorD(IorD), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
    .write_data(write_data), .mem_rdata(mem_rdata), .mem_addr(u1_addr),
    .mem_wdata(u1_wdata), .mem_re(u1_re), .mem_we(u1_we), .ir(u1_ir),
    .mdr(u1_mdr), .busy(u1_busy), .done(u1_done), .misaligned(u1_mis));

  typedef struct {
    bit          rd, wr, iord, irw;
    logic [31:0] pc, alu, wd, rdata;
    logic [31:0] exp_addr, exp_ir, exp_mdr;
    int          exp_we;
    bit          exp_mis;
  } vec_t;

  typedef struct { logic [31:0] ir, mdr; bit mis; } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one request, release it after acceptance while scrambling the
  // address/data inputs, then watch the access until done.
  task automatic run_vec(input int idx, input vec_t v);
    int   busy_n = 0, we_n = 0, we_at = -1, done_at = -1, cyc = 1;
    bit   got = 0, addr_bad = 0, wd_bad = 0;
    exp_t e;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; IorD = v.iord; IRWrite = v.irw;
    pc = v.pc; alu_out = v.alu; write_data = v.wd; mem_rdata = v.rdata;
    sb.push_back('{v.exp_ir, v.exp_mdr, v.exp_mis});
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    pc = 32'hFFFF_FFF0; alu_out = 32'hFFFF_FFF0; write_data = 32'hA5A5_A5A5;
    while (!got && cyc <= 40) begin
      if (busy) begin
        busy_n++;
        if (mem_addr !== v.exp_addr) addr_bad = 1;
        if (mem_wdata !== v.wd) wd_bad = 1;
      end
      if (mem_we) begin we_n++; we_at = cyc; end
      if (done) begin got = 1; done_at = cyc; end
      else begin @(negedge clk); cyc++; end
    end
    chk($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d busy_cycles", idx), busy_n, LAT);
    chk($sformatf("v%0d done_cycle", idx), done_at, LAT + 1);
    chk($sformatf("v%0d we_count", idx), we_n, v.exp_we);
    if (v.exp_we != 0) chk($sformatf("v%0d we_cycle", idx), we_at, LAT);
    chk($sformatf("v%0d addr_stable", idx), 32'(addr_bad), 32'd0);
    chk($sformatf("v%0d wdata_stable", idx), 32'(wd_bad), 32'd0);
    e = sb.pop_front();
    chk($sformatf("v%0d ir", idx), ir, e.ir);
    chk($sformatf("v%0d mdr", idx), mdr, e.mdr);
    chk($sformatf("v%0d misaligned", idx), 32'(misaligned), 32'(e.mis));
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
  endtask

  initial begin
    int we_n;
    bit got;
    vecs[0] = '{1,0,0,1, 32'h10, 32'h0, 32'h0, 32'h00A00093,
                32'h10, 32'h00A00093, 32'h0, 0, 0};
    vecs[1] = '{0,1,1,0, 32'h0, 32'h20, 32'hDEADBEEF, 32'h0,
                32'h20, 32'h00A00093, 32'h0, 1, 0};
    vecs[2] = '{1,0,1,0, 32'h0, 32'h24, 32'h0, 32'h12345678,
                32'h24, 32'h00A00093, 32'h12345678, 0, 0};
    vecs[3] = '{1,0,0,0, 32'h30, 32'h0, 32'h0, 32'hCAFEF00D,
                32'h30, 32'h00A00093, 32'h12345678, 0, 0};
    vecs[4] = '{1,0,1,1, 32'h0, 32'h40, 32'h0, 32'h0BADF00D,
                32'h40, 32'h00A00093, 32'h0BADF00D, 0, 0};
    vecs[5] = '{0,1,1,0, 32'h0, 32'h44, 32'h55AA55AA, 32'h0,
                32'h44, 32'h00A00093, 32'h0BADF00D, 1, 0};
    vecs[6] = '{1,0,1,0, 32'h0, 32'h22, 32'h0, 32'hFFFFFFFF,
                32'h22, 32'h00A00093, ALIGN ? 32'h0BADF00D : 32'hFFFFFFFF, 0, ALIGN};
    vecs[7] = '{0,1,1,0, 32'h0, 32'h26, 32'h01020304, 32'h0,
                32'h26, 32'h00A00093, ALIGN ? 32'h0BADF00D : 32'hFFFFFFFF,
                ALIGN ? 0 : 1, ALIGN};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst ir", ir, 32'h0);
    chk("rst mdr", mdr, 32'h0);
    chk("rst strobes", {27'h0, mem_re, mem_we, busy, done, misaligned}, 32'h0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Read+write held high: one write, then re-acceptance after one IDLE cycle
    @(negedge clk);
    mem_read = 1; mem_write = 1; IorD = 1; IRWrite = 0;
    alu_out = 32'h50; write_data = 32'h11112222; mem_rdata = 32'h77777777;
    we_n = 0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c <= LAT + 1 && mem_we) we_n++;
      if (c <= LAT) chk($sformatf("rw mem_re c%0d", c), 32'(mem_re), 32'd0);
      if (c == LAT + 1) chk("rw done", 32'(done), 32'd1);
      if (c == LAT + 2) chk("rw idle_gap", 32'(busy), 32'd0);
      if (c == LAT + 3) chk("rw reaccept", 32'(busy), 32'd1);
    end
    chk("rw we_count", we_n, 1);
    chk("rw mdr_kept", mdr, ALIGN ? 32'h0BADF00D : 32'hFFFFFFFF);
    mem_read = 0; mem_write = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("rw second_done", 32'(got), 32'd1);
    @(negedge clk);

    // Reset during cycle 2 of a store
    mem_write = 1; IorD = 1; alu_out = 32'h60; write_data = 32'hFEEDFACE;
    we_n = 0;
    @(negedge clk);
    mem_write = 0;
    if (mem_we) we_n++;
    @(negedge clk);
    if (mem_we) we_n++;
    reset = 1;
    @(negedge clk);
    if (mem_we) we_n++;
    chk("rstmid we_count", we_n, 0);
    chk("rstmid mem_addr", mem_addr, 32'h0);
    chk("rstmid mem_wdata", mem_wdata, 32'h0);
    chk("rstmid ir", ir, 32'h0);
    chk("rstmid mdr", mdr, 32'h0);
    chk("rstmid strobes", {27'h0, mem_re, mem_we, busy, done, misaligned}, 32'h0);
    reset = 0;
    @(negedge clk);
    chk("rstmid idle", {30'h0, busy, done}, 32'h0);

    // LATENCY=1 boundary: single BUSY cycle with write strobe, then done
    mem_write = 1; IorD = 1; alu_out = 32'h70; write_data = 32'h0F0F0F0F;
    @(negedge clk);
    mem_write = 0;
    chk("lat1 st busy", 32'(u1_busy), 32'd1);
    chk("lat1 st we", 32'(u1_we), 32'd1);
    chk("lat1 st addr", u1_addr, 32'h70);
    @(negedge clk);
    chk("lat1 st done", {30'h0, u1_done, u1_we}, 32'h2);
    @(negedge clk);
    mem_read = 1; IorD = 1; alu_out = 32'h74; mem_rdata = 32'h600DCAFE;
    @(negedge clk);
    mem_read = 0;
    chk("lat1 rd busy_re", {30'h0, u1_busy, u1_re}, 32'h3);
    @(negedge clk);
    chk("lat1 rd done", 32'(u1_done), 32'd1);
    chk("lat1 rd mdr", u1_mdr, 32'h600DCAFE);
    @(negedge clk);
    chk("lat1 rd done_one", 32'(u1_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory access sequencer between the control unit and the unified instruction/data memory. It accepts a read or write request and latches the address and write data. It holds the memory interface stable for a fixed latency, then captures read data into the instruction register (IR) or the memory data register (MDR). It pulses `done` so the control FSM can leave its fetch or memory states.

## Interface
- `LATENCY`, 4, memory access cycles per request (legal range 1–15)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  input  1  clock; all state updates on the rising edge
- `reset`  input  1  synchronous, active-high reset
- `mem_read`  input  1  read request (level)
- `mem_write`  input  1  write request (level)
- `IorD`  input  1  address select: 0 = `pc` (instruction fetch), 1 = `alu_out` (data access)
- `IRWrite`  input  1  on a fetch read, enables the capture into `ir`
- `pc`  input  ADDR_W  fetch address
- `alu_out`  input  ADDR_W  data address
- `write_data`  input  DATA_W  store data (rs2 value)
- `mem_rdata`  input  DATA_W  memory read data, combinational from `mem_addr`
- `mem_addr`  output  ADDR_W  registered memory address
- `mem_wdata`  output  DATA_W  registered store data
- `mem_re`  output  1  memory read enable
- `mem_we`  output  1  memory write strobe
- `ir`  output  32  instruction register
- `mdr`  output  DATA_W  memory data register
- `busy`  output  1  request in flight
- `done`  output  1  one-cycle completion pulse
- `misaligned`  output  1  sticky error flag for a misaligned access

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - A request exists when `mem_read` or `mem_write` is high.
  - On a request edge: latch `mem_addr` (chosen by `IorD`), `mem_wdata`, the op type, `IorD` and `IRWrite`.
  - Load the counter `cnt` with LATENCY-1, then move to BUSY.
  - If `mem_read` and `mem_write` are both high, the request is treated as a write.
- **BUSY**
  - `busy`=1.
  - `mem_re`=1 for a read.
  - Latched values are held; request inputs are ignored.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the commit at that edge, then move to DONE:
    - Fetch read (latched IorD=0 and IRWrite=1): `ir` ← `mem_rdata`.
    - Data read (IorD=1): `mdr` ← `mem_rdata`.
    - Read with IorD=0 and IRWrite=0: no register is updated.
    - Write: the memory latches data on this edge.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - Inputs are ignored in DONE.
  - A request still asserted in the following IDLE cycle is accepted as a new request.
- `ir` and `mdr` keep their values until the next matching commit.
- `cnt` is 4 bits wide.

## Timing
- Reset values: state=IDLE, `cnt`=0, and every output is 0 (`mem_addr`, `mem_wdata`, `mem_re`, `mem_we`, `ir`, `mdr`, `busy`, `done`, `misaligned`).
- Number the edges from the request-sampling edge E0:
  - BUSY lasts from E0 to E_LATENCY.
  - The commit happens at edge E_LATENCY.
  - `done` is high from E_LATENCY to E_LATENCY+1.
  - Back-to-back requests are therefore spaced LATENCY+2 cycles apart.
- `mem_we` is high only during the final BUSY cycle (`cnt`=0), so exactly one write edge occurs per store.
- With LATENCY=1 there is a single BUSY cycle, and `mem_we`/commit happen at E1.
- `mem_addr` and `mem_wdata` change only on the acceptance edge.
- Reset in any state aborts the access with no commit. A write is suppressed because `mem_we` is zeroed synchronously at the reset edge.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- When defined:
  - A request whose selected address has bits [1:0]≠0 is still sequenced through BUSY and DONE.
  - For that request, `mem_we` stays 0 and no capture into `ir` or `mdr` occurs.
  - `misaligned` is set at the acceptance edge and stays set until reset.
- When undefined:
  - The alignment check hardware is absent and `misaligned` is tied to 0.
  - Addresses pass unmodified, and misaligned accesses commit normally.

## Test plan
- **Fetch read:** reset; pc=0x10, IorD=0, IRWrite=1, mem_read held, mem_rdata=0x00A00093, LATENCY=4.
  - Expect `busy` for 4 cycles and `ir`=0x00A00093 at E4.
  - Expect `done` high for exactly 1 cycle, and `mdr` unchanged.
- **Store:** alu_out=0x20, write_data=0xDEADBEEF, mem_write pulsed 1 cycle.
  - Expect `mem_addr`=0x20 and `mem_wdata`=0xDEADBEEF held for 4 cycles.
  - Expect `mem_we` high only in the 4th cycle.
- **Load:** IorD=1, alu_out=0x24, mem_rdata=0x12345678.
  - Expect `mdr`=0x12345678 and `ir` unchanged.
  - Changing `alu_out` mid-BUSY must not move `mem_addr`.
- **Simultaneous read and write:** mem_read=mem_write=1.
  - Expect a write sequence with `mem_we` asserted once.
  - Keep both requests high through DONE and expect re-acceptance in the next IDLE cycle.
- **Reset mid-store:** assert reset at cycle 2 of a store.
  - Expect no `mem_we` pulse, all outputs 0, and IDLE on the next edge.
- **Misaligned data read (MEM_ALIGN_CHECK_EN defined):** alu_out=0x22.
  - Expect `done` after LATENCY cycles, `mdr` unchanged, and `misaligned`=1 sticky until reset.
  - With the macro undefined, `misaligned` stays 0.
